commit_trace_buffer: RTL and testbench
======================================

# commit_trace_buffer

Parametrised retirement trace capture for `pipeline_cpu`. It replaces the ad-hoc per-cycle `$display` trace with a synthesizable block. The block snoops the WB-stage register-file write and the MEM-stage data-memory write, then packs each retiring event into an entry. Entries are buffered in a DEPTH-deep FIFO and drained through a valid/ready port by a host, a UART bridge or a bench scoreboard, so the same trace works in simulation and on silicon.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 4 or more.
- `PC_W`, 32: PC field width.
- `DATA_W`, 32: register and memory data width.
- `MADDR_W`, 10: word address width (`address[11:2]`).
- `OVERWRITE`, 0: 0 drops new events when full; 1 discards the oldest entry instead.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low.
- `clear` in 1: synchronous flush of FIFO, counters and flag.
- `cap_en` in 1: capture enable; events are ignored while low.
- `pc_wb` in PC_W: PC of the retiring instruction.
- `reg_write` in 1: GPR write strobe (WB stage).
- `num_write` in 5: GPR index.
- `data_write` in DATA_W: GPR write data.
- `mem_write` in 1: data-memory write strobe.
- `mem_addr` in MADDR_W: word address.
- `mem_data` in DATA_W: store data.
- `out_valid` out 1: head entry is valid.
- `out_ready` in 1: consumer accepts the head entry.
- `out_entry` out ENTRY_W: head entry.
- `level` out clog2(DEPTH)+1: occupancy.
- `drop_cnt` out 16: lost events; saturates at 16'hFFFF.
- `overflow` out 1: sticky; set by any loss.

## Operation
- Event: `cap_en && (reg_write || mem_write)`.
- Entry fields, MSB to LSB: `{[TS], kind[1:0], pc_wb, num_write, data_write, mem_addr, mem_data}`.
  - `kind[0]` = reg_write; `kind[1]` = mem_write.
  - Fields of the inactive kind are zero.
- A GPR write and a memory write in the same cycle form one entry with kind = 2'b11.
- `reg_write` with `num_write == 0` is still logged. Filtering is the consumer's job.
- Pop happens when `out_valid && out_ready`.
- Full with a push and no pop:
  - OVERWRITE=0: the event is discarded.
  - OVERWRITE=1: the head is discarded, the read pointer advances and the new entry is written.
  - In both cases `drop_cnt` is incremented and `overflow` is set.
- Full with a simultaneous push and pop: both proceed normally, with no loss.
- Empty with a simultaneous push and pop: the pop is invalid because `out_valid` is 0. The push is accepted.
- Pointers are clog2(DEPTH) bits and wrap naturally. `level` is tracked explicitly and ranges 0..DEPTH.
- `clear` has priority over push and pop in the same cycle. The event presented that cycle is not captured.

## Timing
- Reset (async assert, sync release) sets `out_valid`=0, `level`=0, `drop_cnt`=0, `overflow`=0, `out_entry`=0, pointers=0 and timestamp=0. The memory array is not reset.
- Capture latency is 1 cycle: an event at edge N appears on `out_entry` / `out_valid` after edge N. `out_entry` is read fall-through from `rd_ptr`.
- `out_entry` is stable while `out_valid && !out_ready`. In OVERWRITE=1 the head changes when the buffer is full and an event arrives.
- `level` and `drop_cnt` update on the same edge as the push or pop.
- Reset mid-drain aborts the drain immediately. Un-drained entries are lost and `out_valid` falls asynchronously.

## Configuration
- `TRACE_TIMESTAMP_EN` defined:
  - A free-running 32-bit cycle counter runs from reset and is cleared by `clear`; it wraps.
  - Its value at capture is prepended as field `TS`.
  - ENTRY_W = 32 + 2 + PC_W + 5 + 2·DATA_W + MADDR_W.
- Undefined: no counter and no TS field. ENTRY_W = 2 + PC_W + 5 + 2·DATA_W + MADDR_W.

## Structure
- Shared package `trace_pkg` holds:
  - the `KIND_REG`/`KIND_MEM` bit positions;
  - the field-width localparams and the ENTRY_W computation;
  - the entry field offsets, for use by the bench decoder.
- One sub-module: `trace_fifo`, a generic DEPTH×ENTRY_W fall-through FIFO with the overwrite mode. Packing, counters and the flag stay in the top level.

## Test plan
- Reset, then reg_write num=5 data=32'h0000000A pc=32'h8 → after 1 cycle `out_valid`=1, kind=01, fields match, `level`=1.
- reg_write and mem_write in the same cycle, addr=10'h004, data=32'h0000000F → one entry, kind=11, `level`=1.
- OVERWRITE=0, DEPTH=4, `out_ready`=0, 6 events → `level`=4, head is event 1, `drop_cnt`=2, `overflow`=1.
- OVERWRITE=1, same stimulus → `level`=4, head is event 3, `drop_cnt`=2.
- Full buffer with push and pop in the same cycle → `level` stays 4, `drop_cnt` unchanged. Then drain 4 entries → order preserved and `out_valid`=0.
- `reset` low for 3 ns mid-drain → all outputs zero immediately. `clear` pulse with a coincident event → `level`=0 and the event is not captured. With TRACE_TIMESTAMP_EN, the TS difference of back-to-back events equals the cycle gap.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace: kind bits, field widths and entry layout.
// Layout MSB..LSB: {[ts], kind, pc, num, data, maddr, mdata}; ts present only with TRACE_TIMESTAMP_EN.
package trace_pkg;

  localparam int KIND_REG = 0;
  localparam int KIND_MEM = 1;

  localparam int KIND_W = 2;
  localparam int NUM_W  = 5;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W   = 32;
`else
  localparam int TS_W   = 0;
`endif

  localparam int PC_W_DEF    = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int MADDR_W_DEF = 10;

  function automatic int body_w(input int pc_w, input int data_w, input int maddr_w);
    return KIND_W + pc_w + NUM_W + 2 * data_w + maddr_w;
  endfunction

  function automatic int entry_w(input int pc_w, input int data_w, input int maddr_w);
    return TS_W + body_w(pc_w, data_w, maddr_w);
  endfunction

  // Field LSB offsets within an entry
  function automatic int off_maddr(input int data_w);
    return data_w;
  endfunction

  function automatic int off_data(input int data_w, input int maddr_w);
    return data_w + maddr_w;
  endfunction

  function automatic int off_num(input int data_w, input int maddr_w);
    return 2 * data_w + maddr_w;
  endfunction

  function automatic int off_pc(input int data_w, input int maddr_w);
    return 2 * data_w + maddr_w + NUM_W;
  endfunction

  function automatic int off_kind(input int pc_w, input int data_w, input int maddr_w);
    return off_pc(data_w, maddr_w) + pc_w;
  endfunction

  function automatic int off_ts(input int pc_w, input int data_w, input int maddr_w);
    return body_w(pc_w, data_w, maddr_w);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Fall-through FIFO with explicit occupancy; when full, a push either drops
// (OVERWRITE=0) or evicts the oldest entry (OVERWRITE=1). drop pulses on either loss.
module trace_fifo #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 32,
  parameter int OVERWRITE = 0,
  localparam int AW       = $clog2(DEPTH),
  localparam int LW       = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, pop_ok, lost, wr_en, rd_adv;

  assign full   = (level == LW'(DEPTH));
  assign valid  = (level != '0);
  assign pop_ok = pop && valid;
  // Full push without a matching pop is a loss in both modes
  assign lost   = push && full && !pop_ok && !clear;
  assign wr_en  = push && !clear && (!full || pop_ok || (OVERWRITE != 0));
  assign rd_adv = !clear && (pop_ok || (lost && (OVERWRITE != 0)));
  assign drop   = lost;

  assign dout = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_adv)      level <= level + 1'b1;
      else if (rd_adv && !wr_en) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement trace capture: packs WB reg writes and MEM stores into FIFO entries.
// Define TRACE_TIMESTAMP_EN to prepend a 32-bit free-running cycle stamp to each entry.
module commit_trace_buffer import trace_pkg::*; #(
  parameter int DEPTH     = 16,
  parameter int PC_W      = 32,
  parameter int DATA_W    = 32,
  parameter int MADDR_W   = 10,
  parameter int OVERWRITE = 0
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     clear,
  input  logic                                     cap_en,
  input  logic [PC_W-1:0]                          pc_wb,
  input  logic                                     reg_write,
  input  logic [4:0]                               num_write,
  input  logic [DATA_W-1:0]                        data_write,
  input  logic                                     mem_write,
  input  logic [MADDR_W-1:0]                       mem_addr,
  input  logic [DATA_W-1:0]                        mem_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [entry_w(PC_W, DATA_W, MADDR_W)-1:0] out_entry,
  output logic [$clog2(DEPTH):0]                   level,
  output logic [15:0]                              drop_cnt,
  output logic                                     overflow
);

  localparam int BODY_W  = body_w(PC_W, DATA_W, MADDR_W);
  localparam int ENTRY_W = entry_w(PC_W, DATA_W, MADDR_W);

  logic                evt, push, fifo_drop;
  logic [1:0]          kind;
  logic [4:0]          num_m;
  logic [DATA_W-1:0]   rdata_m, mdata_m;
  logic [MADDR_W-1:0]  maddr_m;
  logic [BODY_W-1:0]   body;
  logic [ENTRY_W-1:0]  entry;

  assign evt  = cap_en && (reg_write || mem_write);
  assign push = evt && !clear;

  assign kind[KIND_REG] = reg_write;
  assign kind[KIND_MEM] = mem_write;

  // Fields of an inactive kind are forced to zero so entries compare cleanly
  assign num_m   = reg_write ? num_write  : 5'd0;
  assign rdata_m = reg_write ? data_write : '0;
  assign maddr_m = mem_write ? mem_addr   : '0;
  assign mdata_m = mem_write ? mem_data   : '0;

  assign body = {kind, pc_wb, num_m, rdata_m, maddr_m, mdata_m};

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     ts_q <= '0;
    else if (clear) ts_q <= '0;
    else            ts_q <= ts_q + 32'd1;
  end

  assign entry = {ts_q, body};
`else
  assign entry = body;
`endif

  trace_fifo #(
    .DEPTH    (DEPTH),
    .WIDTH    (ENTRY_W),
    .OVERWRITE(OVERWRITE)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .din   (entry),
    .pop   (out_ready),
    .valid (out_valid),
    .dout  (out_entry),
    .level (level),
    .drop  (fifo_drop)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: drop-mode and overwrite-mode instances share stimulus,
// each checked against its own queue model.
module tb_commit_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH  = 4;
  localparam int BODY_W = body_w(32, 32, 10);
  localparam int EW     = entry_w(32, 32, 10);
  localparam int KOFF   = off_kind(32, 32, 10);
  localparam int POFF   = off_pc(32, 10);
  localparam int NOFF   = off_num(32, 10);
  localparam int DOFF   = off_data(32, 10);

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0, cap_en = 1'b0, reg_write = 1'b0, mem_write = 1'b0, out_ready = 1'b0;
  logic [31:0] pc_wb = '0, data_write = '0, mem_data = '0;
  logic [4:0]  num_write = '0;
  logic [9:0]  mem_addr = '0;

  logic          out_valid_a, out_valid_b, overflow_a, overflow_b;
  logic [EW-1:0] out_entry_a, out_entry_b;
  logic [2:0]    level_a, level_b;
  logic [15:0]   drop_cnt_a, drop_cnt_b;

  always #5 clock = ~clock;

  commit_trace_buffer #(.DEPTH(DEPTH), .OVERWRITE(0)) u_drop (
    .clock(clock), .reset(reset), .clear(clear), .cap_en(cap_en), .pc_wb(pc_wb),
    .reg_write(reg_write), .num_write(num_write), .data_write(data_write),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_entry(out_entry_a),
    .level(level_a), .drop_cnt(drop_cnt_a), .overflow(overflow_a));

  commit_trace_buffer #(.DEPTH(DEPTH), .OVERWRITE(1)) u_ovw (
    .clock(clock), .reset(reset), .clear(clear), .cap_en(cap_en), .pc_wb(pc_wb),
    .reg_write(reg_write), .num_write(num_write), .data_write(data_write),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_entry(out_entry_b),
    .level(level_b), .drop_cnt(drop_cnt_b), .overflow(overflow_b));

  int checks = 0;
  int fails  = 0;

  logic [BODY_W-1:0] qa[$], qb[$];
  int   drop_a = 0, drop_b = 0;
  logic ovf_a = 1'b0, ovf_b = 1'b0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [BODY_W-1:0] make_body(input logic rw, input logic [4:0] n,
      input logic [31:0] d, input logic mw, input logic [9:0] a, input logic [31:0] md,
      input logic [31:0] pc);
    return {mw, rw, pc, rw ? n : 5'd0, rw ? d : 32'd0, mw ? a : 10'd0, mw ? md : 32'd0};
  endfunction

  task automatic model_reset();
    qa.delete(); qb.delete();
    drop_a = 0; drop_b = 0; ovf_a = 1'b0; ovf_b = 1'b0;
  endtask

  // Drive one cycle, compare heads popped this cycle, update the model, check state after the edge
  task automatic ev(input logic ce, input logic rw, input logic [4:0] n, input logic [31:0] d,
      input logic mw, input logic [9:0] a, input logic [31:0] md, input logic [31:0] pc,
      input logic rdy, input logic clr);
    logic [BODY_W-1:0] e;
    logic is_ev, pa, pb;
    int   sa, sb;
    cap_en = ce; reg_write = rw; num_write = n; data_write = d; mem_write = mw;
    mem_addr = a; mem_data = md; pc_wb = pc; out_ready = rdy; clear = clr;
    #1;
    e = make_body(rw, n, d, mw, a, md, pc);
    is_ev = ce && (rw || mw);
    if (clr) begin
      model_reset();
    end else begin
      sa = qa.size(); sb = qb.size();
      pa = rdy && (sa > 0);
      pb = rdy && (sb > 0);
      if (pa) begin chk("head_drop", out_entry_a[BODY_W-1:0], qa[0]); void'(qa.pop_front()); end
      if (pb) begin chk("head_ovw",  out_entry_b[BODY_W-1:0], qb[0]); void'(qb.pop_front()); end
      if (is_ev) begin
        if (sa == DEPTH && !pa) begin drop_a++; ovf_a = 1'b1; end
        else qa.push_back(e);
        if (sb == DEPTH && !pb) begin drop_b++; ovf_b = 1'b1; void'(qb.pop_front()); qb.push_back(e); end
        else qb.push_back(e);
      end
    end
    @(posedge clock); #1;
    chk("level_drop", level_a, qa.size());
    chk("level_ovw",  level_b, qb.size());
    chk("valid_drop", out_valid_a, qa.size() > 0);
    chk("valid_ovw",  out_valid_b, qb.size() > 0);
    chk("dropcnt_drop", drop_cnt_a, drop_a);
    chk("dropcnt_ovw",  drop_cnt_b, drop_b);
    chk("ovf_drop", overflow_a, ovf_a);
    chk("ovf_ovw",  overflow_b, ovf_b);
    cap_en = 1'b0; reg_write = 1'b0; mem_write = 1'b0; out_ready = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    ev(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 10'd0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic rw_ev(input int i, input logic rdy);
    ev(1'b1, 1'b1, 5'(i), 32'(i * 17), 1'b0, 10'd0, 32'd0, 32'(i * 4), rdy, 1'b0);
  endtask

  typedef struct {
    logic        ce, rw, mw;
    logic [4:0]  n;
    logic [31:0] d, md, pc;
    logic [9:0]  a;
    logic [1:0]  exp_kind;
    logic [2:0]  exp_level;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{ce:1, rw:1, mw:0, n:5,  d:32'h0000000A, md:0,            pc:32'h8,   a:0,      exp_kind:2'b01, exp_level:1};
    tbl[1] = '{ce:1, rw:1, mw:1, n:3,  d:32'h0000000F, md:32'h0000000F, pc:32'hC,   a:10'h004, exp_kind:2'b11, exp_level:1};
    tbl[2] = '{ce:1, rw:0, mw:1, n:7,  d:32'h11111111, md:32'hDEADBEEF, pc:32'h100, a:10'h3FF, exp_kind:2'b10, exp_level:1};
    tbl[3] = '{ce:1, rw:1, mw:0, n:0,  d:32'h00001234, md:0,            pc:32'h104, a:0,      exp_kind:2'b01, exp_level:1};
    tbl[4] = '{ce:0, rw:1, mw:1, n:9,  d:32'h55555555, md:32'h66666666, pc:32'h108, a:10'h010, exp_kind:2'b00, exp_level:0};

    // Reset state
    #3;
    chk("rst_valid", out_valid_a, 1'b0);
    chk("rst_level", level_b, 3'd0);
    chk("rst_entry", out_entry_a, '0);
    chk("rst_drop",  drop_cnt_b, 16'd0);
    chk("rst_ovf",   overflow_a, 1'b0);
    #4 reset = 1'b1;
    @(posedge clock); #1;

    // Single-event patterns
    foreach (tbl[i]) begin
      ev(tbl[i].ce, tbl[i].rw, tbl[i].n, tbl[i].d, tbl[i].mw, tbl[i].a, tbl[i].md, tbl[i].pc, 1'b0, 1'b0);
      chk("vec_kind",  out_entry_a[KOFF +: 2], tbl[i].exp_kind);
      chk("vec_level", level_a, tbl[i].exp_level);
      if (tbl[i].exp_kind != 2'b00) begin
        chk("vec_pc", out_entry_a[POFF +: 32], tbl[i].pc);
        if (tbl[i].rw) begin
          chk("vec_num",  out_entry_a[NOFF +: 5],  tbl[i].n);
          chk("vec_data", out_entry_a[DOFF +: 32], tbl[i].d);
        end
      end
      idle(1'b1);
    end

    // Six events into a stalled DEPTH=4 buffer
    for (int i = 1; i <= 6; i++) rw_ev(i, 1'b0);
    chk("fill_head_drop", out_entry_a[POFF +: 32], 32'd4);
    chk("fill_head_ovw",  out_entry_b[POFF +: 32], 32'd12);
    chk("fill_dropcnt",   drop_cnt_a, 16'd2);
    chk("fill_level",     level_b, 3'd4);

    // Full with push and pop together: no loss
    rw_ev(7, 1'b1);
    chk("fullpp_level",   level_a, 3'd4);
    chk("fullpp_dropcnt", drop_cnt_b, 16'd2);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drained_valid", out_valid_b, 1'b0);

    // Empty with push and pop together: push accepted
    rw_ev(8, 1'b1);
    idle(1'b1);

    // Clear beats a coincident event
    rw_ev(9, 1'b0);
    rw_ev(10, 1'b0);
    ev(1'b1, 1'b1, 5'd11, 32'd11, 1'b1, 10'd11, 32'd11, 32'd44, 1'b0, 1'b1);
    chk("clr_level", level_a, 3'd0);
    chk("clr_ovf",   overflow_b, 1'b0);
    chk("clr_valid", out_valid_b, 1'b0);

    // Async reset mid-drain
    for (int i = 12; i < 15; i++) rw_ev(i, 1'b0);
    idle(1'b1);
    reset = 1'b0;
    #1;
    chk("arst_valid_a", out_valid_a, 1'b0);
    chk("arst_valid_b", out_valid_b, 1'b0);
    chk("arst_level",   level_a, 3'd0);
    chk("arst_entry",   out_entry_b, '0);
    chk("arst_drop",    drop_cnt_b, 16'd0);
    #2 reset = 1'b1;
    model_reset();
    rw_ev(15, 1'b0);
    idle(1'b1);

`ifdef TRACE_TIMESTAMP_EN
    begin
      logic [31:0] ts1, ts2;
      rw_ev(16, 1'b0);
      idle(1'b0); idle(1'b0); idle(1'b0);
      rw_ev(17, 1'b0);
      ts1 = out_entry_a[off_ts(32, 32, 10) +: 32];
      idle(1'b1);
      ts2 = out_entry_a[off_ts(32, 32, 10) +: 32];
      chk("ts_gap", ts2 - ts1, 32'd4);
      idle(1'b1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
